// File: rtl/aes256_dec_if.sv
// Bus between an AES-256 block decryptor and its host / round-key store.
//   valid, addr, ciphertext : host write strobe, target select, write data
//   rk_idx, rk              : round-key request and same-cycle key reply
//   decData, done, busy     : plaintext result, completion pulse, in-flight flag
//   err                     : dropped-write pulse (only with AES256_DEC_ERR_EN)
// Macro AES256_DEC_ERR_EN adds the err signal to both modports.
interface aes256_dec_if;
  logic         valid;
  logic         addr;
  logic [127:0] ciphertext;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic [127:0] decData;
  logic         done;
  logic         busy;
`ifdef AES256_DEC_ERR_EN
  logic         err;
`endif

  // Host side: issues writes and also serves as the round-key store.
  modport master (
    output valid, addr, ciphertext, rk,
    input  rk_idx, decData, done, busy
`ifdef AES256_DEC_ERR_EN
    , input err
`endif
  );

  // Decryptor side.
  modport slave (
    input  valid, addr, ciphertext, rk,
    output rk_idx, decData, done, busy
`ifdef AES256_DEC_ERR_EN
    , output err
`endif
  );
endinterface

// File: rtl/aes256_dec.sv
// Iterative AES-256 block decryptor, one round per clock, 15 cycles per block.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : aes256_dec_if.slave (host writes, round-key request/reply, result)
// A control write (addr=0) stores ctrl[7:0]; ctrl[0] enables decryption.
// A data write (addr=1) starts a block when idle and enabled; other writes drop.
// Macro AES256_DEC_ERR_EN adds a one-cycle err pulse after every dropped write.
module aes256_dec #(
  parameter int unsigned N  = 16,
  parameter int unsigned NR = 14
) (
  input  logic        clk,
  input  logic        reset,
  aes256_dec_if.slave bus
);
  localparam int unsigned W  = N * 8;
  localparam int unsigned RW = 4;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_FINAL
  } state_t;

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant k (used for 9, b, d, e) as a sum of x^i * a.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  // InvShiftRows then InvSubBytes; byte r+4c is row r, column c.
  function automatic logic [W-1:0] inv_shift_sub(input logic [W-1:0] s);
    logic [W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[W-8-8*(r+4*c) +: 8] = INV_SBOX[s[W-8-8*(r+4*((c+4-r)%4)) +: 8]];
      end
    end
    return o;
  endfunction

  // InvMixColumns, one 32-bit column at a time.
  function automatic logic [W-1:0] inv_mix(input logic [W-1:0] s);
    logic [W-1:0] o;
    logic [31:0]  col;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      col = s[W-1-32*c -: 32];
      a0  = col[31:24];
      a1  = col[23:16];
      a2  = col[15:8];
      a3  = col[7:0];
      o[W-1-32*c -: 32] = {
        gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
        gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
        gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
        gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)
      };
    end
    return o;
  endfunction

  state_t          r_fsm,    w_fsm;
  logic [7:0]      r_ctrl,   w_ctrl;
  logic [W-1:0]    r_state,  w_state;
  logic [W-1:0]    r_dec,    w_dec;
  logic            r_done,   w_done;
  logic            r_busy,   w_busy;
  logic [RW-1:0]   r_round,  w_round;
  logic [RW-1:0]   r_rk_idx, w_rk_idx;
  logic            w_drop;
  logic [W-1:0]    w_core;

  // Shared round core: AddRoundKey(InvSubBytes(InvShiftRows(state)), rk).
  assign w_core = inv_shift_sub(r_state) ^ bus.rk;

  // Next-state and datapath decode.
  always_comb begin
    w_fsm    = r_fsm;
    w_ctrl   = r_ctrl;
    w_state  = r_state;
    w_dec    = r_dec;
    w_done   = 1'b0;
    w_busy   = r_busy;
    w_round  = r_round;
    w_rk_idx = r_rk_idx;
    w_drop   = 1'b0;
    unique case (r_fsm)
      S_IDLE: begin
        if (bus.valid) begin
          if (!bus.addr) begin
            w_ctrl = bus.ciphertext[7:0];
          end else if (r_ctrl[0]) begin
            // rk currently carries key NR, the initial whitening key.
            w_state  = bus.ciphertext ^ bus.rk;
            w_busy   = 1'b1;
            w_round  = RW'(NR - 1);
            w_rk_idx = RW'(NR - 1);
            w_fsm    = S_ROUND;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      S_ROUND: begin
        w_drop  = bus.valid;
        w_state = inv_mix(w_core);
        w_round = r_round - RW'(1);
        if (r_round == RW'(1)) begin
          w_rk_idx = '0;
          w_fsm    = S_FINAL;
        end else begin
          w_rk_idx = r_round - RW'(1);
        end
      end
      S_FINAL: begin
        w_drop   = bus.valid;
        w_dec    = w_core;
        w_done   = 1'b1;
        w_busy   = 1'b0;
        w_rk_idx = RW'(NR);
        w_fsm    = S_IDLE;
      end
      default: begin
        w_fsm    = S_IDLE;
        w_rk_idx = RW'(NR);
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm    <= S_IDLE;
      r_ctrl   <= '0;
      r_state  <= '0;
      r_dec    <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_round  <= '0;
      r_rk_idx <= RW'(NR);
    end else begin
      r_fsm    <= w_fsm;
      r_ctrl   <= w_ctrl;
      r_state  <= w_state;
      r_dec    <= w_dec;
      r_done   <= w_done;
      r_busy   <= w_busy;
      r_round  <= w_round;
      r_rk_idx <= w_rk_idx;
    end
  end

  assign bus.rk_idx  = r_rk_idx;
  assign bus.decData = r_dec;
  assign bus.done    = r_done;
  assign bus.busy    = r_busy;

  // ctrl[7:1] are reserved: stored but never read.
  logic w_unused_ctrl;
  assign w_unused_ctrl = ^r_ctrl[7:1];

`ifdef AES256_DEC_ERR_EN
  logic r_err;

  // Pulse one cycle after any dropped write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_drop;
    end
  end

  assign bus.err = r_err;
`else
  logic w_unused_drop;
  assign w_unused_drop = w_drop;
`endif
endmodule

// File: tb/tb_aes256_dec.sv
// Scoreboard bench for aes256_dec. Random plaintexts are encrypted by a forward
// AES-256 model kept here; the resulting ciphertext is written to the DUT and
// the plaintext is queued as the expected result with its expected done cycle.
module tb_aes256_dec;
  localparam logic [127:0] KNOWN_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] KNOWN_PT = 128'h00112233445566778899aabbccddeeff;

  localparam logic [7:0] INV_SB [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef struct {
    logic [127:0] pt;
    int           due;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   t_acc = 0;

  logic [7:0]   sbox  [256];
  logic [127:0] rkeys [16];

  exp_t         q[$];
  string        cq_tag[$];
  logic [127:0] cq_act[$];
  logic [127:0] cq_exp[$];

  aes256_dec_if bus();

  aes256_dec dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Key store: expanded key word group for the requested index.
  assign bus.rk = rkeys[bus.rk_idx];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
  endfunction

  // Forward AES-256 cipher (FIPS-197 Cipher()).
  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] v;
    v = pt ^ rkeys[0];
    for (int r = 1; r <= 14; r++) begin
      for (int k = 0; k < 16; k++) s[k] = sbox[v[127-8*k -: 8]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[w+4*c] = s[w+4*((c+w)%4)];
      if (r != 14) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int k = 0; k < 16; k++) v[127-8*k -: 8] = t[k];
      v = v ^ rkeys[r];
    end
    return v;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    cq_tag.push_back(tag);
    cq_act.push_back(act);
    cq_exp.push_back(exp);
  endtask

  task automatic wr(input logic a, input logic [127:0] d);
    bus.valid      = 1'b1;
    bus.addr       = a;
    bus.ciphertext = d;
    @(negedge clk);
    bus.valid = 1'b0;
  endtask

  task automatic send_ct(input logic [127:0] ct, input logic [127:0] pt);
    exp_t e;
    e.pt  = pt;
    e.due = cyc + 15;
    q.push_back(e);
    t_acc = cyc;
    wr(1'b1, ct);
  endtask

  task automatic send(input logic [127:0] pt);
    send_ct(aes_enc(pt), pt);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || bus.busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      check("timeout_idle", 128'(0), 128'(1));
      q.delete();
    end
  endtask

  // Monitor: drains posted checks and scores every done pulse.
  initial begin
    string        m_tag;
    logic [127:0] m_act, m_exp;
    exp_t         m_e;
    forever begin
      @(negedge clk);
      while (cq_tag.size() != 0) begin
        m_tag = cq_tag.pop_front();
        m_act = cq_act.pop_front();
        m_exp = cq_exp.pop_front();
        n_vec++;
        if (m_act !== m_exp) begin
          n_bad++;
          $display("FAIL %s: got %h want %h", m_tag, m_act, m_exp);
        end
      end
      if (bus.done) begin
        n_vec++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_done: got done with decData %h at cycle %0d, want no done", bus.decData, cyc);
        end else begin
          m_e = q.pop_front();
          if (bus.decData !== m_e.pt || cyc != m_e.due) begin
            n_bad++;
            $display("FAIL done_data: got %h at cycle %0d, want %h at cycle %0d", bus.decData, cyc, m_e.pt, m_e.due);
          end
        end
      end
    end
  end

  // Stimulus.
  initial begin
    logic [31:0]  w [60];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] pa, pb;

    for (int i = 0; i < 256; i++) sbox[INV_SB[i]] = 8'(i);
    for (int i = 0; i < 8; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end else if (i % 8 == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int r = 0; r < 15; r++) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    rkeys[15] = '0;

    reset          = 1'b1;
    bus.valid      = 1'b0;
    bus.addr       = 1'b0;
    bus.ciphertext = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",    128'(bus.busy),   128'(0));
    check("rst_done",    128'(bus.done),   128'(0));
    check("rst_decData", bus.decData,      128'(0));
    check("rst_rk_idx",  128'(bus.rk_idx), 128'(14));
`ifdef AES256_DEC_ERR_EN
    check("rst_err",     128'(bus.err),    128'(0));
`endif
    reset = 1'b0;
    @(negedge clk);

    // Known FIPS-197 C.3 vector.
    wr(1'b0, 128'h01);
    send_ct(KNOWN_CT, KNOWN_PT);
    check("busy_after_accept", 128'(bus.busy), 128'(1));
    wait_idle();

    // Disabled: data write must be dropped.
    wr(1'b0, 128'h00);
    wr(1'b1, KNOWN_CT);
    check("disabled_busy", 128'(bus.busy), 128'(0));
`ifdef AES256_DEC_ERR_EN
    check("disabled_err", 128'(bus.err), 128'(1));
    @(negedge clk);
    check("err_one_cycle", 128'(bus.err), 128'(0));
`endif
    repeat (20) @(negedge clk);
    check("disabled_hold", bus.decData, KNOWN_PT);

    // Writes while busy are dropped (data at cycle 5, ctrl later).
    wr(1'b0, 128'h01);
    pa = rnd128();
    send(pa);
    wait_until(t_acc + 5);
    wr(1'b1, aes_enc(rnd128()));
`ifdef AES256_DEC_ERR_EN
    check("busy_drop_err", 128'(bus.err), 128'(1));
`endif
    wait_until(t_acc + 8);
    wr(1'b0, 128'h00);
    wait_idle();
    repeat (5) @(negedge clk);
    check("result_holds", bus.decData, pa);

    // Ctrl write while busy was dropped, so enable is still set.
    send(rnd128());
    wait_idle();

    // Reset at round 7 aborts the block.
    send(rnd128());
    wait_until(t_acc + 7);
    check("rk_idx_round7", 128'(bus.rk_idx), 128'(7));
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy",    128'(bus.busy),   128'(0));
    check("abort_decData", bus.decData,      128'(0));
    check("abort_rk_idx",  128'(bus.rk_idx), 128'(14));
    wr(1'b1, KNOWN_CT);
    check("enable_cleared", 128'(bus.busy), 128'(0));
    repeat (18) @(negedge clk);
    wr(1'b0, 128'h01);
    send_ct(KNOWN_CT, KNOWN_PT);
    wait_idle();

    // Back-to-back: second block written in the done cycle.
    pa = rnd128();
    pb = rnd128();
    send(pa);
    for (int i = 0; i < 40; i++) begin
      if (bus.done) break;
      @(negedge clk);
    end
    if (bus.done) begin
      send(pb);
    end else begin
      check("timeout_done", 128'(0), 128'(1));
    end
    wait_idle();

    // Random blocks with random gaps.
    for (int i = 0; i < 6; i++) begin
      send(rnd128());
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    check("scoreboard_empty", 128'(q.size()), 128'(0));
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
